// File: rtl/fifo_pkt_ctrl.sv
// Packet-level write/read control for a plain fifo_memory array: framing, lengths, full/empty, overflow.
// Optional build macro FIFO_PKT_DROP_OVERSIZE_EN discards oversize packets instead of truncating them.
module fifo_pkt_ctrl #(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [UWIDTH-1:0]    in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 mem_write_en,
  output logic [PTR_SZ-1:0]    mem_waddr,
  output logic [PTR_IN_SZ-1:0] mem_waddr_in,
  output logic [UWIDTH-1:0]    mem_wdata,
  output logic                 mem_read_en,
  output logic [PTR_SZ-1:0]    mem_raddr,
  output logic [PTR_IN_SZ-1:0] mem_raddr_in,
  input  logic [UWIDTH-1:0]    mem_rdata,
  output logic [PTR_SZ:0]      count,
  output logic                 ovf_err
);

  localparam logic [PTR_SZ:0]      DEPTH_C = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_SZ:0]      CNT_ONE = (PTR_SZ+1)'(1);
  localparam logic [PTR_SZ-1:0]    PTR_MAX = PTR_SZ'(DEPTH-1);
  localparam logic [PTR_SZ-1:0]    PTR_ONE = PTR_SZ'(1);
  localparam logic [PTR_IN_SZ-1:0] WIDTH_C = PTR_IN_SZ'(WIDTH);
  localparam logic [PTR_IN_SZ-1:0] IDX_ONE = PTR_IN_SZ'(1);

  logic [PTR_SZ-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_IN_SZ-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [PTR_IN_SZ-1:0] len_q [DEPTH];
  logic [PTR_IN_SZ-1:0] len_new;
  logic [PTR_SZ:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 wr_acc, commit, oversize, store, rd_acc, release_pkt;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PTR_SZ-1:0] ptrInc(input logic [PTR_SZ-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_ONE;
  endfunction

  assign in_ready     = (count_q < DEPTH_C);
  assign wr_acc       = in_valid && in_ready;
  assign mem_write_en = wr_acc && (wr_idx_q < WIDTH_C);
  assign mem_waddr    = wptr_q;
  assign mem_waddr_in = wr_idx_q;
  assign mem_wdata    = in_data;

  // wr_idx saturates at WIDTH, so reaching it at in_last means at least WIDTH+1 bytes arrived.
  assign commit   = wr_acc && in_last;
  assign oversize = (wr_idx_q == WIDTH_C);
  assign len_new  = oversize ? WIDTH_C : wr_idx_q + IDX_ONE;
`ifdef FIFO_PKT_DROP_OVERSIZE_EN
  assign store = commit && !oversize;
`else
  assign store = commit;
`endif

  assign out_valid    = (count_q != '0);
  assign out_last     = out_valid && (rd_idx_q == len_q[rptr_q] - IDX_ONE);
  assign out_data     = mem_rdata;
  assign mem_read_en  = out_valid;
  assign mem_raddr    = rptr_q;
  assign mem_raddr_in = rd_idx_q;
  assign rd_acc       = out_valid && out_ready;
  assign release_pkt  = rd_acc && out_last;
  assign count        = count_q;
  assign ovf_err      = ovf_q;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    ovf_d    = commit && oversize;
    if (wr_acc) begin
      if (in_last)       wr_idx_d = '0;
      else if (!oversize) wr_idx_d = wr_idx_q + IDX_ONE;
    end
    if (store) wptr_d = ptrInc(wptr_q);
    if (rd_acc) begin
      if (out_last) begin
        rd_idx_d = '0;
        rptr_d   = ptrInc(rptr_q);
      end else begin
        rd_idx_d = rd_idx_q + IDX_ONE;
      end
    end
    case ({store, release_pkt})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) len_q[i] <= IDX_ONE;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (store) len_q[wptr_q] <= len_new;
    end
  end

endmodule
